// File: rtl/nn_img_pkg.sv
// nn_img_pkg: shared defaults and FSM encoding for the image buffer controller.
// Default widths and buffer depth live here so the controller and its address
// generator agree on them without repeating literals.
package nn_img_pkg;

  localparam int NN_DATA_WIDTH      = 8;
  localparam int NN_ADDR_WIDTH      = 10;
  localparam int NN_DEPTH           = 128;
  localparam int NN_PIXELS_PER_WORD = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bf_state_t;

endpackage

// File: rtl/nn_addr_gen.sv
// nn_addr_gen: strided read address generator for the image buffer.
// Loading captures the first address and the stride; each step adds the stride.
// DEPTH is a power of two that divides 2^ADDR_WIDTH, so masking the sum gives
// the address modulo DEPTH even when the ADDR_WIDTH-bit addition wraps.
module nn_addr_gen
  import nn_img_pkg::*;
#(
  parameter int ADDR_WIDTH = NN_ADDR_WIDTH,
  parameter int DEPTH      = NN_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic                  i_step,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;

  // Current address and stride; the address holds whenever neither load nor step is asked
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else if (i_load) begin
      addr_q   <= i_base & ADDR_MASK;
      stride_q <= i_stride;
    end else if (i_step) begin
      addr_q   <= (addr_q + stride_q) & ADDR_MASK;
    end
  end

  assign o_addr = addr_q;

endmodule

// File: rtl/nn_img_bf_ctrl.sv
// nn_img_bf_ctrl: image buffer controller.
// Accepts loader words into a circular buffer while idle and runs strided read
// jobs out of it, returning each word one cycle after its address is issued.
// Optional feature: define NN_IMG_BF_CTRL_OVF_CHK_EN to stop accepting writes
// once the buffer is full and raise a sticky overflow flag instead of wrapping.
module nn_img_bf_ctrl
  import nn_img_pkg::*;
#(
  parameter int DATA_WIDTH       = NN_DATA_WIDTH,
  parameter int ADDR_WIDTH       = NN_ADDR_WIDTH,
  parameter int DEPTH            = NN_DEPTH,
  parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * NN_PIXELS_PER_WORD
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_valid,
  input  logic [TOTAL_DATA_WIDTH-1:0] i_wr_data,
  output logic                        o_wr_ready,
  input  logic                        i_clear,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_rd_base,
  input  logic [ADDR_WIDTH-1:0]       i_rd_len,
  input  logic [ADDR_WIDTH-1:0]       i_rd_stride,
  output logic                        o_bf_wr_en,
  output logic [ADDR_WIDTH-1:0]       o_bf_wr_addr,
  output logic [TOTAL_DATA_WIDTH-1:0] o_bf_wr_data,
  output logic                        o_bf_rd_en,
  output logic [ADDR_WIDTH-1:0]       o_bf_rd_addr,
  input  logic [TOTAL_DATA_WIDTH-1:0] i_bf_rd_data,
  output logic [TOTAL_DATA_WIDTH-1:0] o_rd_data,
  output logic                        o_rd_valid,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [ADDR_WIDTH:0]         o_fill_cnt,
  output logic                        o_ovf
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   FULL_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  bf_state_t state_q;
  bf_state_t state_d;

  logic [ADDR_WIDTH-1:0]       len_q;
  logic [ADDR_WIDTH-1:0]       rd_cnt_q;
  logic [ADDR_WIDTH-1:0]       wr_ptr_q;
  logic [ADDR_WIDTH:0]         fill_q;
  logic                        rd_valid_q;
  logic [TOTAL_DATA_WIDTH-1:0] rd_data_q;

  logic wr_ready;
  logic wr_accept;
  logic wr_block;
  logic rd_en;
  logic busy;
  logic done;
  logic start_accept;
  logic addr_load;
  logic addr_step;
  logic [ADDR_WIDTH-1:0] rd_addr;

`ifdef NN_IMG_BF_CTRL_OVF_CHK_EN
  assign wr_block = (fill_q == FULL_CNT);
`else
  assign wr_block = 1'b0;
`endif

  assign wr_accept = i_wr_valid & wr_ready;

  // State register; reset always lands in IDLE, which also aborts a running job
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; a job with zero length goes straight to DONE
  always_comb begin
    state_d      = state_q;
    wr_ready     = 1'b0;
    rd_en        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    start_accept = 1'b0;
    addr_load    = 1'b0;
    addr_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_ready = ~i_clear & ~wr_block;
        if (i_start) begin
          start_accept = 1'b1;
          if (i_rd_len == '0) begin
            state_d = ST_DONE;
          end else begin
            addr_load = 1'b1;
            state_d   = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (rd_cnt_q == (len_q - ADDR_ONE)) begin
          state_d = ST_DONE;
        end else begin
          addr_step = 1'b1;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Job length and issued-read counter, captured when a job is launched
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_q    <= '0;
      rd_cnt_q <= '0;
    end else if (start_accept) begin
      len_q    <= i_rd_len;
      rd_cnt_q <= '0;
    end else if (addr_step) begin
      rd_cnt_q <= rd_cnt_q + ADDR_ONE;
    end
  end

  // Write pointer and fill level; clear rewinds both and beats a same-cycle write
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (wr_accept) begin
      wr_ptr_q <= (wr_ptr_q + ADDR_ONE) & ADDR_MASK;
      if (fill_q != FULL_CNT) begin
        fill_q <= fill_q + CNT_ONE;
      end
    end
  end

`ifdef NN_IMG_BF_CTRL_OVF_CHK_EN
  logic ovf_q;

  // Sticky overflow: any write attempt while full sets it until reset or clear
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      ovf_q <= 1'b0;
    end else if (i_wr_valid && (fill_q == FULL_CNT)) begin
      ovf_q <= 1'b1;
    end
  end

  assign o_ovf = ovf_q;
`else
  assign o_ovf = 1'b0;
`endif

  // Read return stage: the buffer answers combinationally, so one register gives latency 1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= i_bf_rd_data;
      end
    end
  end

  nn_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_addr_gen (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (addr_load),
    .i_base   (i_rd_base),
    .i_stride (i_rd_stride),
    .i_step   (addr_step),
    .o_addr   (rd_addr)
  );

  assign o_wr_ready   = wr_ready;
  assign o_bf_wr_en   = wr_accept;
  assign o_bf_wr_addr = wr_ptr_q;
  assign o_bf_wr_data = i_wr_data;
  assign o_bf_rd_en   = rd_en;
  assign o_bf_rd_addr = rd_addr;
  assign o_rd_data    = rd_data_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_busy       = busy;
  assign o_done       = done;
  assign o_fill_cnt   = fill_q;

endmodule
